display_scanner: RTL

Time-multiplexed scan controller for an NDIG-digit common-anode seven-segment display. It sits directly upstream of the hex-to-seven-segment decoder. It latches a packed hex word, selects one nibble per scan slot, drives the decoder's `Val`/`IDLE` inputs, and drives the active-low digit-select lines. Anti-ghosting blank slots, leading-zero blanking and tear-free frame updates are handled here, so the decoder stays purely combinational.

---
 rtl/display_pkg.sv | 30 +++
 rtl/scan_prescaler.sv | 29 ++
 rtl/display_scanner.sv | 137 +++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package display_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // Widest supported display; narrower instances slice these.
    localparam int unsigned MAX_DIG = 8;
    localparam int unsigned MAX_W   = 4 * MAX_DIG;

    // All digit selects released (active-low).
    localparam logic [MAX_DIG-1:0] DIG_OFF = '1;

    // Bit i set when digit i is a leading zero: i != 0 and every nibble j >= i is zero.
    function automatic logic [MAX_DIG-1:0] lz_mask(input logic [MAX_W-1:0] dsp);
        logic [MAX_DIG-1:0] m;
        logic               zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = MAX_DIG - 1; i >= 0; i--) begin
            zero_above = zero_above && (dsp[4*i +: 4] == 4'h0);
            m[i]       = (i != 0) && zero_above;
        end
        return m;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Per-slot cycle counter; Tick marks the last drive cycle of a slot.
module scan_prescaler #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    input  logic Run,
    output logic Tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt;

    assign Tick = Run && (cnt == CW'(PRESCALE - 1));

    // Count while running, wrap at PRESCALE-1, synchronous clear wins.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (Clear) begin
            cnt <= '0;
        end else if (Run) begin
            cnt <= Tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
module display_scanner
    import display_pkg::*;
#(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              Load,
    input  logic [4*NDIG-1:0] Data,
    output logic [3:0]        Val,
    output logic              IDLE,
    output logic [NDIG-1:0]   Dig,
    output logic              Pending
);

    localparam int unsigned IW = $clog2(NDIG);

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] shd_q, shd_d;
    logic [4*NDIG-1:0] dsp_q, dsp_d;
    logic              pend_d;
    logic              tick;
    logic              wrap;
    logic              last;
    logic              commit;
    logic [MAX_W-1:0]  dsp_pad;
    logic [MAX_DIG-1:0] lz_vec;
    logic [NDIG-1:0]   dig_d;
    logic [3:0]        val_d;
    logic              idle_d;

    // Counter only runs in DRIVE; anything else (including a drop of Enable) zeroes it.
    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .Clock (Clock),
        .Reset (Reset),
        .Clear ((state_q != ST_DRIVE) || !Enable),
        .Run   ((state_q == ST_DRIVE) && Enable),
        .Tick  (tick)
    );

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a low Enable overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF:   if (Enable) state_d = ST_BLANK;
            ST_BLANK: state_d = Enable ? ST_DRIVE : ST_OFF;
            ST_DRIVE: begin
                if (!Enable) begin
                    state_d = ST_OFF;
                end else if (tick) begin
                    state_d = ST_BLANK;
                end
            end
            default:  state_d = ST_OFF;
        endcase
    end

    // Digit index and the shadow/display commit path.
    always_comb begin
        wrap   = (state_q == ST_DRIVE) && tick;
        last   = (idx_q == IW'(NDIG - 1));
        commit = (state_q == ST_OFF) || (wrap && last);

        idx_d = idx_q;
        if (state_d == ST_OFF) begin
            idx_d = '0;
        end else if (wrap) begin
            idx_d = last ? '0 : idx_q + 1'b1;
        end

        shd_d  = shd_q;
        dsp_d  = dsp_q;
        pend_d = Pending;
        if (commit) begin
            // A load on a commit cycle bypasses into dsp; shd tracks it so OFF keeps it.
            dsp_d  = Load ? Data : shd_q;
            shd_d  = Load ? Data : shd_q;
            pend_d = 1'b0;
        end else if (Load) begin
            shd_d  = Data;
            pend_d = 1'b1;
        end
    end

    // Output decode from the state being entered, so outputs can be registered.
    always_comb begin
        dsp_pad               = '0;
        dsp_pad[4*NDIG-1:0]   = dsp_d;
        lz_vec                = lz_mask(dsp_pad);
        dig_d                 = DIG_OFF[NDIG-1:0];
        val_d                 = 4'h0;
        idle_d                = 1'b1;
        if (state_d == ST_DRIVE) begin
            dig_d[idx_d] = 1'b0;
            val_d        = dsp_d[{idx_d, 2'b00} +: 4];
            idle_d       = BLANK_LZ && lz_vec[idx_d];
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            idx_q   <= '0;
            shd_q   <= '0;
            dsp_q   <= '0;
            Pending <= 1'b0;
            Val     <= 4'h0;
            IDLE    <= 1'b1;
            Dig     <= DIG_OFF[NDIG-1:0];
        end else begin
            idx_q   <= idx_d;
            shd_q   <= shd_d;
            dsp_q   <= dsp_d;
            Pending <= pend_d;
            Val     <= val_d;
            IDLE    <= idle_d;
            Dig     <= dig_d;
        end
    end

endmodule
